// File: rtl/seg_rx_pkg.sv
// Shared types and constants for the seven-segment serial link receiver.
// The segment pattern table is the same one the display encoder drives.
package seg_rx_pkg;

    localparam int unsigned FRAME_BITS_DEF = 64;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_e;

    // Active-low patterns for hex digits 0..F, bits 6:0 = g..a, bit 7 = point (off).
    localparam logic [7:0] SEG_PAT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Returns {hit, digit}; the point bit is ignored and a miss yields 5'b0.
    function automatic logic [4:0] seg_decode(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[6:0] == SEG_PAT[i][6:0]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_sync_edge.sv
// Multi-flop synchronizer for one link input, followed by an edge-detect flop.
module seg_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/seg_s2p_rx.sv
// Seven-segment serial link receiver: rebuilds 64-bit frames in the clk domain.
// Optional hex decoder enabled by defining SEG_RX_DECODE_EN.
module seg_s2p_rx
    import seg_rx_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_clk,
    input  logic                  seg_clrn,
    input  logic                  seg_sout,
    input  logic                  SEG_PEN,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt,
    output logic [31:0]           hex_out,
    output logic [7:0]            hex_ok
);

    localparam int unsigned CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    logic clk_rise;
    logic clrn_lvl;
    logic sout_lvl;
    logic pen_rise;

    seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .din(seg_clk), .lvl(), .rise(clk_rise), .fall()
    );
    seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clrn (
        .clk(clk), .rst(rst), .din(seg_clrn), .lvl(clrn_lvl), .rise(), .fall()
    );
    seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sout (
        .clk(clk), .rst(rst), .din(seg_sout), .lvl(sout_lvl), .rise(), .fall()
    );
    seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_pen (
        .clk(clk), .rst(rst), .din(SEG_PEN), .lvl(), .rise(pen_rise), .fall()
    );

    rx_state_e            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_base;
    logic [CW-1:0]         cnt_nxt;
    logic [FRAME_BITS-1:0] sh_nxt;
    logic                  clr;
    logic                  frame_good;
    logic                  frame_bad;

    assign clr = ~clrn_lvl;

    // Shift is applied before frame evaluation so a coincident PEN edge sees it.
    always_comb begin
        cnt_base = (state == IDLE) ? '0 : cnt;
        sh_nxt   = shreg;
        cnt_nxt  = cnt_base;
        if (clk_rise) begin
            sh_nxt = {shreg[FRAME_BITS-2:0], sout_lvl};
            if (cnt_base != CNT_SAT) cnt_nxt = cnt_base + 1'b1;
        end
        frame_good = pen_rise && !clr && (cnt_nxt == CNT_FULL);
        frame_bad  = pen_rise && !frame_good;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            rx_data     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= frame_good;
            frame_err   <= frame_bad;
            if (clr) begin
                state <= IDLE;
                shreg <= '0;
                cnt   <= '0;
            end else if (pen_rise) begin
                state <= IDLE;
                shreg <= sh_nxt;
                cnt   <= '0;
            end else begin
                shreg <= sh_nxt;
                cnt   <= cnt_nxt;
                if (clk_rise) state <= SHIFT;
            end
            if (frame_good) begin
                rx_data   <= sh_nxt;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef SEG_RX_DECODE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out <= '0;
            hex_ok  <= '0;
        end else if (frame_good) begin
            for (int k = 0; k < 8; k++) begin
                {hex_ok[k], hex_out[4*k +: 4]} <= seg_decode(sh_nxt[8*k +: 8]);
            end
        end
    end
`else
    assign hex_out = '0;
    assign hex_ok  = '0;
`endif

endmodule

// File: tb/tb_seg_s2p_rx.sv
// Self-checking bench for seg_s2p_rx: directed frames plus random frames
// compared against a bit-queue reference model.
module tb_seg_s2p_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seg_clk = 1'b0;
    logic        seg_clrn = 1'b1;
    logic        seg_sout = 1'b0;
    logic        SEG_PEN = 1'b0;
    logic [63:0] rx_data;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  frame_cnt;
    logic [31:0] hex_out;
    logic [7:0]  hex_ok;

    seg_s2p_rx dut (
        .clk(clk), .rst(rst), .seg_clk(seg_clk), .seg_clrn(seg_clrn),
        .seg_sout(seg_sout), .SEG_PEN(SEG_PEN), .rx_data(rx_data),
        .frame_valid(frame_valid), .frame_err(frame_err), .frame_cnt(frame_cnt),
        .hex_out(hex_out), .hex_ok(hex_ok)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
    end

    // Reference model: bits seen since the last frame end / clear / reset.
    logic        q[$];
    logic [63:0] m_rx = '0;
    logic [7:0]  m_cnt = '0;
    logic [31:0] m_hex = '0;
    logic [7:0]  m_ok = '0;
    int          exp_valid = 0;
    int          exp_err = 0;

    // Active-high 0..F digit shapes; the link carries their inverse.
    logic [6:0] shape [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        seg_sout = b;
        cyc(4);
        seg_clk = 1'b1;
        cyc(4);
        seg_clk = 1'b0;
        q.push_back(b);
    endtask

    task automatic send_bits(input logic [69:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_clear();
        seg_clrn = 1'b0;
        cyc(5);
        seg_clrn = 1'b1;
        cyc(5);
        q.delete();
    endtask

    task automatic end_frame();
        logic [63:0] d;
        SEG_PEN = 1'b1;
        cyc(8);
        SEG_PEN = 1'b0;
        cyc(4);
        if (q.size() == 64) begin
            d = '0;
            foreach (q[i]) d = {d[62:0], q[i]};
            m_rx = d;
            m_cnt = m_cnt + 8'd1;
            exp_valid++;
`ifdef SEG_RX_DECODE_EN
            for (int k = 0; k < 8; k++) begin
                m_hex[4*k +: 4] = 4'h0;
                m_ok[k] = 1'b0;
                for (int j = 0; j < 16; j++) begin
                    if (~d[8*k +: 7] == shape[j]) begin
                        m_hex[4*k +: 4] = 4'(j);
                        m_ok[k] = 1'b1;
                    end
                end
            end
`endif
        end else begin
            exp_err++;
        end
        q.delete();
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rx_data"}, rx_data, m_rx);
        chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(m_cnt));
        chk({tag, ".n_valid"}, 64'(n_valid), 64'(exp_valid));
        chk({tag, ".n_err"}, 64'(n_err), 64'(exp_err));
        chk({tag, ".hex_out"}, 64'(hex_out), 64'(m_hex));
        chk({tag, ".hex_ok"}, 64'(hex_ok), 64'(m_ok));
    endtask

    initial begin
        logic [63:0] v;
        int          len;
        cyc(3);
        chk_all("reset");
        rst = 1'b0;
        cyc(5);

        // Known frame, MSB first.
        send_bits(70'h0123456789ABCDEF, 64);
        end_frame();
        chk_all("known");
        chk("known.cnt1", 64'(frame_cnt), 64'd1);

        // Short frame rejected, next full frame accepted.
        send_bits(70'h2AAAAAAAAAAAAAAA, 63);
        end_frame();
        chk_all("short63");
        send_bits(70'hFEDCBA9876543210, 64);
        end_frame();
        chk_all("after_short");

        // Overlong frame saturates and is rejected.
        send_bits(70'h15_5555_5555_5555_5555, 70);
        end_frame();
        chk_all("long70");

        // Clear discards a partial frame.
        send_bits(70'h12_3456_789A, 40);
        do_clear();
        send_bits(70'hFFFF_FFFF_0000_0000, 64);
        end_frame();
        chk_all("clear");
        chk("clear.data", rx_data, 64'hFFFF_FFFF_0000_0000);

        // Digit patterns 7..0 with a blank in byte 3.
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = {1'b1, ~shape[k]};
        v[31:24] = 8'hFF;
        send_bits(70'(v), 64);
        end_frame();
        chk_all("digits");
`ifdef SEG_RX_DECODE_EN
        chk("digits.hex_lit", 64'(hex_out), 64'h76540210);
        chk("digits.ok_lit", 64'(hex_ok), 64'hF7);
`endif

        // Random frames, mostly full length.
        for (int f = 0; f < 10; f++) begin
            v = {$urandom, $urandom};
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 69) : 64;
            if ($urandom_range(0, 4) == 0) begin
                send_bits(70'($urandom), $urandom_range(1, 20));
                do_clear();
            end
            send_bits({6'($urandom), v}, len);
            end_frame();
            chk_all($sformatf("rand%0d", f));
        end

        // Reset mid-frame, then a partial frame.
        send_bits(70'h3ABCDEF1, 30);
        rst = 1'b1;
        cyc(3);
        q.delete();
        m_rx = '0; m_cnt = '0; m_hex = '0; m_ok = '0;
        chk("rst.rx_data", rx_data, 64'd0);
        chk("rst.frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst.hex_out", 64'(hex_out), 64'd0);
        chk("rst.hex_ok", 64'(hex_ok), 64'd0);
        rst = 1'b0;
        cyc(5);
        send_bits(70'h2_DEAD_BEEF, 34);
        end_frame();
        chk_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
